// File: rtl/rv_iopmp_tl_dispatcher.sv
// rtl/rv_iopmp_tl_dispatcher.sv - routes IOPMP check requests from requester ports to a pool of TL instances
package rv_iopmp_pkg;
    typedef enum logic [1:0] {
        ACCESS_NONE      = 2'd0,
        ACCESS_READ      = 2'd1,
        ACCESS_WRITE     = 2'd2,
        ACCESS_EXECUTION = 2'd3
    } access_t;
endpackage

module rv_iopmp_tl_dispatcher #(
    parameter int unsigned ADDR_WIDTH          = 64,
    parameter int unsigned DATA_WIDTH          = 64,
    parameter int unsigned SID_WIDTH           = 1,
    parameter int unsigned NUM_PORTS           = 2,
    parameter int unsigned NUMBER_TL_INSTANCES = 2,
    localparam int unsigned NB                 = $clog2(DATA_WIDTH / 8) + 1
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic [NUM_PORTS-1:0]                         port_req_valid_i,
    output logic [NUM_PORTS-1:0]                         port_req_ready_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]              port_addr_i,
    input  logic [NUM_PORTS*NB-1:0]                      port_num_bytes_i,
    input  logic [NUM_PORTS*SID_WIDTH-1:0]               port_sid_i,
    input  rv_iopmp_pkg::access_t [NUM_PORTS-1:0]        port_access_type_i,
    output logic [NUM_PORTS-1:0]                         port_rsp_valid_o,
    output logic [NUM_PORTS-1:0]                         port_allow_o,
    output logic [NUMBER_TL_INSTANCES-1:0]               tl_transaction_en_o,
    output logic [NUMBER_TL_INSTANCES*ADDR_WIDTH-1:0]    tl_addr_o,
    output logic [NUMBER_TL_INSTANCES*NB-1:0]            tl_num_bytes_o,
    output logic [NUMBER_TL_INSTANCES*SID_WIDTH-1:0]     tl_sid_o,
    output rv_iopmp_pkg::access_t [NUMBER_TL_INSTANCES-1:0] tl_access_type_o,
    input  logic [NUMBER_TL_INSTANCES-1:0]               tl_ready_i,
    input  logic [NUMBER_TL_INSTANCES-1:0]               tl_valid_i,
    input  logic [NUMBER_TL_INSTANCES-1:0]               tl_allow_i,
    output logic [NUMBER_TL_INSTANCES-1:0]               busy_o,
    output logic                                         protocol_err_o
);

    localparam int unsigned OW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUMBER_TL_INSTANCES-1:0] inst_busy;
    logic [OW-1:0]                  owner [NUMBER_TL_INSTANCES];
    logic [NUM_PORTS-1:0]           port_busy;
    logic [OW-1:0]                  rr_ptr;
    logic [NUM_PORTS-1:0]           rsp_valid_q;
    logic [NUM_PORTS-1:0]           rsp_allow_q;
    logic                           protocol_err_q;

    logic [NUM_PORTS-1:0]           eligible;
    logic [NUM_PORTS-1:0]           port_granted;
    logic [NUMBER_TL_INSTANCES-1:0] grant_valid;
    logic [OW-1:0]                  grant_port [NUMBER_TL_INSTANCES];
    logic [OW-1:0]                  cand;
    logic [OW-1:0]                  last_port;
    logic                           any_grant;
    logic [OW-1:0]                  rr_ptr_d;

    assign eligible = port_req_valid_i & ~port_busy;

    // Walk free instances in ascending order; each takes the next ungranted eligible port from rr_ptr
    always_comb begin
        port_granted = '0;
        grant_valid  = '0;
        any_grant    = 1'b0;
        last_port    = '0;
        cand         = '0;
        for (int k = 0; k < int'(NUMBER_TL_INSTANCES); k++) begin
            grant_port[k] = '0;
        end
        for (int k = 0; k < int'(NUMBER_TL_INSTANCES); k++) begin
            if (!inst_busy[k] && tl_ready_i[k]) begin
                for (int i = 0; i < int'(NUM_PORTS); i++) begin
                    cand = OW'((32'(rr_ptr) + 32'(i)) % NUM_PORTS);
                    if (!grant_valid[k] && eligible[cand] && !port_granted[cand]) begin
                        grant_valid[k]     = 1'b1;
                        grant_port[k]      = cand;
                        port_granted[cand] = 1'b1;
                        any_grant          = 1'b1;
                        last_port          = cand;
                    end
                end
            end
        end
        rr_ptr_d = any_grant ? OW'((32'(last_port) + 32'd1) % NUM_PORTS) : rr_ptr;
    end

    // Steer the granted port's request fields to each instance; idle instances see zeros
    always_comb begin
        tl_addr_o      = '0;
        tl_num_bytes_o = '0;
        tl_sid_o       = '0;
        for (int k = 0; k < int'(NUMBER_TL_INSTANCES); k++) begin
            tl_access_type_o[k] = rv_iopmp_pkg::ACCESS_NONE;
            if (grant_valid[k]) begin
                tl_addr_o[k*ADDR_WIDTH +: ADDR_WIDTH] =
                    port_addr_i[int'(grant_port[k])*ADDR_WIDTH +: ADDR_WIDTH];
                tl_num_bytes_o[k*NB +: NB] =
                    port_num_bytes_i[int'(grant_port[k])*NB +: NB];
                tl_sid_o[k*SID_WIDTH +: SID_WIDTH] =
                    port_sid_i[int'(grant_port[k])*SID_WIDTH +: SID_WIDTH];
                tl_access_type_o[k] = port_access_type_i[grant_port[k]];
            end
        end
    end

    // Ownership tracking, response routing by owner, pointer advance and sticky protocol error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inst_busy      <= '0;
            port_busy      <= '0;
            rr_ptr         <= '0;
            rsp_valid_q    <= '0;
            rsp_allow_q    <= '0;
            protocol_err_q <= 1'b0;
            for (int k = 0; k < int'(NUMBER_TL_INSTANCES); k++) begin
                owner[k] <= '0;
            end
        end else begin
            rsp_valid_q <= '0;
            rsp_allow_q <= '0;
            rr_ptr      <= rr_ptr_d;
            for (int k = 0; k < int'(NUMBER_TL_INSTANCES); k++) begin
                if (tl_valid_i[k]) begin
                    if (inst_busy[k]) begin
                        inst_busy[k]              <= 1'b0;
                        port_busy[owner[k]]       <= 1'b0;
                        rsp_valid_q[owner[k]]     <= 1'b1;
                        rsp_allow_q[owner[k]]     <= tl_allow_i[k];
                    end else begin
                        protocol_err_q <= 1'b1;
                    end
                end
            end
            // A port is never granted while it owns an instance, so these never collide with releases above
            for (int k = 0; k < int'(NUMBER_TL_INSTANCES); k++) begin
                if (grant_valid[k]) begin
                    inst_busy[k]             <= 1'b1;
                    owner[k]                 <= grant_port[k];
                    port_busy[grant_port[k]] <= 1'b1;
                end
            end
        end
    end

    assign port_req_ready_o    = port_granted;
    assign tl_transaction_en_o = grant_valid;
    assign port_rsp_valid_o    = rsp_valid_q;
    assign port_allow_o        = rsp_allow_q;
    assign busy_o              = inst_busy;
    assign protocol_err_o      = protocol_err_q;

endmodule

// File: tb/tb_rv_iopmp_tl_dispatcher.sv
// tb/tb_rv_iopmp_tl_dispatcher.sv - directed self-checking bench for rv_iopmp_tl_dispatcher
module tb_rv_iopmp_tl_dispatcher;

    logic                             clk;
    logic                             rst_n;
    logic [1:0]                       req_valid;
    logic [1:0]                       req_ready;
    logic [127:0]                     p_addr;
    logic [7:0]                       p_nb;
    logic [1:0]                       p_sid;
    rv_iopmp_pkg::access_t [1:0]      p_acc;
    logic [1:0]                       rsp_valid;
    logic [1:0]                       allow;
    logic [1:0]                       tl_en;
    logic [127:0]                     tl_addr;
    logic [7:0]                       tl_nb;
    logic [1:0]                       tl_sid;
    rv_iopmp_pkg::access_t [1:0]      tl_acc;
    logic [1:0]                       tl_ready;
    logic [1:0]                       tl_valid;
    logic [1:0]                       tl_allow;
    logic [1:0]                       busy;
    logic                             err;

    int checks = 0;
    int errors = 0;
    int exp_p;

    rv_iopmp_tl_dispatcher #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .SID_WIDTH(1),
        .NUM_PORTS(2), .NUMBER_TL_INSTANCES(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .port_req_valid_i(req_valid), .port_req_ready_o(req_ready),
        .port_addr_i(p_addr), .port_num_bytes_i(p_nb), .port_sid_i(p_sid),
        .port_access_type_i(p_acc),
        .port_rsp_valid_o(rsp_valid), .port_allow_o(allow),
        .tl_transaction_en_o(tl_en), .tl_addr_o(tl_addr), .tl_num_bytes_o(tl_nb),
        .tl_sid_o(tl_sid), .tl_access_type_o(tl_acc),
        .tl_ready_i(tl_ready), .tl_valid_i(tl_valid), .tl_allow_i(tl_allow),
        .busy_o(busy), .protocol_err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        p_addr    = {64'h2000, 64'h1000};
        p_nb      = {4'd4, 4'd8};
        p_sid     = 2'b10;
        p_acc     = {rv_iopmp_pkg::ACCESS_WRITE, rv_iopmp_pkg::ACCESS_READ};
        tl_ready  = 2'b00;
        tl_valid  = 2'b00;
        tl_allow  = 2'b00;

        // reset state
        tick();
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_rsp", 64'(rsp_valid), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_en", 64'(tl_en), 64'h0);
        tick();
        rst_n = 1'b1;

        // both ports, both instances free: port0->TL0, port1->TL1
        req_valid = 2'b11;
        tl_ready  = 2'b11;
        @(negedge clk);
        chk("t2_ready", 64'(req_ready), 64'h3);
        chk("t2_en", 64'(tl_en), 64'h3);
        chk("t2_addr0", tl_addr[63:0], 64'h1000);
        chk("t2_addr1", tl_addr[127:64], 64'h2000);
        chk("t2_nb", 64'(tl_nb), 64'h48);
        chk("t2_sid", 64'(tl_sid), 64'h2);
        chk("t2_acc", 64'(tl_acc), 64'h9);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("t2_busy", 64'(busy), 64'h3);
        chk("t2_ready_off", 64'(req_ready), 64'h0);
        // out-of-order: TL1 (allow=0) completes before TL0 (allow=1)
        tick();
        tl_valid = 2'b10;
        tl_allow = 2'b00;
        @(negedge clk);
        chk("t4_rsp_none", 64'(rsp_valid), 64'h0);
        tick();
        tl_valid = 2'b01;
        tl_allow = 2'b01;
        @(negedge clk);
        chk("t4_rsp_p1", 64'(rsp_valid), 64'h2);
        chk("t4_allow_p1", 64'(allow), 64'h0);
        chk("t4_busy", 64'(busy), 64'h1);
        tick();
        tl_valid = 2'b00;
        tl_allow = 2'b00;
        @(negedge clk);
        chk("t4_rsp_p0", 64'(rsp_valid), 64'h1);
        chk("t4_allow_p0", 64'(allow), 64'h1);
        chk("t4_busy_free", 64'(busy), 64'h0);
        tick();
        @(negedge clk);
        chk("t4_rsp_end", 64'(rsp_valid), 64'h0);

        // single request, port0 -> TL0, result after three cycles
        tick();
        req_valid = 2'b01;
        @(negedge clk);
        chk("t1_ready", 64'(req_ready), 64'h1);
        chk("t1_en", 64'(tl_en), 64'h1);
        chk("t1_addr0", tl_addr[63:0], 64'h1000);
        chk("t1_addr1_idle", tl_addr[127:64], 64'h0);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("t1_busy_c1", 64'(busy), 64'h1);
        tick();
        @(negedge clk);
        chk("t1_busy_c2", 64'(busy), 64'h1);
        tick();
        tl_valid = 2'b01;
        tl_allow = 2'b01;
        @(negedge clk);
        chk("t1_busy_c3", 64'(busy), 64'h1);
        chk("t1_rsp_early", 64'(rsp_valid), 64'h0);
        tick();
        tl_valid = 2'b00;
        tl_allow = 2'b00;
        @(negedge clk);
        chk("t1_rsp", 64'(rsp_valid), 64'h1);
        chk("t1_allow", 64'(allow), 64'h1);
        chk("t1_busy_free", 64'(busy), 64'h0);
        tick();
        @(negedge clk);
        chk("t1_rsp_end", 64'(rsp_valid), 64'h0);

        // one usable instance, continuous requests, latency 2: grants alternate 1,0,1,0
        tick();
        tl_ready  = 2'b01;
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            exp_p = (g % 2 == 0) ? 1 : 0;
            @(negedge clk);
            chk("t3_ready", 64'(req_ready), 64'(1 << exp_p));
            chk("t3_en", 64'(tl_en), 64'h1);
            if (g == 0) begin
                chk("t3_rsp_first", 64'(rsp_valid), 64'h0);
            end else begin
                chk("t3_rsp", 64'(rsp_valid), 64'(1 << (1 - exp_p)));
                chk("t3_allow", 64'(allow), (exp_p == 0) ? 64'h2 : 64'h0);
            end
            tick();
            @(negedge clk);
            chk("t3_hold", 64'(req_ready), 64'h0);
            chk("t3_busy", 64'(busy), 64'h1);
            chk("t3_rsp_gap", 64'(rsp_valid), 64'h0);
            tick();
            tl_valid = 2'b01;
            tl_allow = (exp_p == 1) ? 2'b01 : 2'b00;
            @(negedge clk);
            chk("t3_hold2", 64'(req_ready), 64'h0);
            tick();
            tl_valid = 2'b00;
            tl_allow = 2'b00;
        end
        req_valid = 2'b00;
        @(negedge clk);
        chk("t3_rsp_last", 64'(rsp_valid), 64'h1);
        chk("t3_allow_last", 64'(allow), 64'h0);
        chk("t3_ready_last", 64'(req_ready), 64'h0);
        tick();
        @(negedge clk);
        chk("t3_rsp_width", 64'(rsp_valid), 64'h0);
        chk("t3_busy_end", 64'(busy), 64'h0);

        // spurious completion on idle TL1
        tick();
        tl_ready = 2'b11;
        tl_valid = 2'b10;
        tl_allow = 2'b10;
        @(negedge clk);
        chk("t5_err_before", 64'(err), 64'h0);
        tick();
        tl_valid = 2'b00;
        tl_allow = 2'b00;
        @(negedge clk);
        chk("t5_err", 64'(err), 64'h1);
        chk("t5_rsp", 64'(rsp_valid), 64'h0);
        chk("t5_busy", 64'(busy), 64'h0);
        tick();
        @(negedge clk);
        chk("t5_err_sticky", 64'(err), 64'h1);

        // rr_ptr is 1 here: port1->TL0, port0->TL1; then reset while both busy
        tick();
        req_valid = 2'b11;
        @(negedge clk);
        chk("t6_ready", 64'(req_ready), 64'h3);
        chk("t6_addr0", tl_addr[63:0], 64'h2000);
        chk("t6_addr1", tl_addr[127:64], 64'h1000);
        chk("t6_sid", 64'(tl_sid), 64'h1);
        chk("t6_nb", 64'(tl_nb), 64'h84);
        chk("t6_acc", 64'(tl_acc), 64'h6);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("t6_busy", 64'(busy), 64'h3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 64'(busy), 64'h0);
        chk("t6_rst_err", 64'(err), 64'h0);
        chk("t6_rst_rsp", 64'(rsp_valid), 64'h0);
        chk("t6_rst_en", 64'(tl_en), 64'h0);
        tick();
        rst_n     = 1'b1;
        req_valid = 2'b01;
        @(negedge clk);
        chk("t6_post_ready", 64'(req_ready), 64'h1);
        chk("t6_post_addr", tl_addr[63:0], 64'h1000);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("t6_post_busy", 64'(busy), 64'h1);
        tick();
        tl_valid = 2'b01;
        tl_allow = 2'b00;
        tick();
        tl_valid = 2'b00;
        @(negedge clk);
        chk("t6_post_rsp", 64'(rsp_valid), 64'h1);
        chk("t6_post_allow", 64'(allow), 64'h0);
        chk("t6_post_free", 64'(busy), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
